bus_drv_fifo: RTL and testbench
===============================

// Module: bus_drv_fifo
// PURPOSE
//  Per-device transmit FIFO feeding one port of the bs_gnrtr_n_rbtr bus arbiter.
//  Device side writes packets; bus side sees show-ahead pndng/D_pop and issues pop.
//  One instance per driver (DRVS instances); replaces the bench-side FIFO model at integration.
// PARAMETERS
//  pckg_sz   16   packet width in bits; must match the arbiter pckg_sz
//  depth     8    FIFO entries; power of 2, >= 2
//  af_lvl    6    almost_full asserts when count >= af_lvl (1..depth)
// PORTS
//  clk          in   1                    system clock, rising edge
//  reset_n      in   1                    asynchronous reset, active low
//  wr_en        in   1                    device push request
//  wr_data      in   pckg_sz              device packet
//  full         out  1                    count == depth
//  almost_full  out  1                    count >= af_lvl
//  overflow     out  1                    1-cycle pulse: write dropped while full
//  pop          in   1                    arbiter consumes head entry
//  pndng        out  1                    FIFO not empty (count != 0)
//  D_pop        out  pckg_sz              head entry, valid while pndng=1
//  count        out  $clog2(depth+1)      current occupancy
//  ovf_cnt      out  16                   [BUS_FIFO_STATS_EN only] dropped-write counter
//  hwm          out  $clog2(depth+1)      [BUS_FIFO_STATS_EN only] occupancy high-water mark
// BEHAVIOUR
//  - Reset (async assert, sync release): rd_ptr=wr_ptr=0, count=0, pndng=0, full=0,
//    almost_full=0, overflow=0, D_pop=0; memory contents not cleared. Mid-operation reset
//    discards all entries immediately; first post-reset write behaves as into empty FIFO.
//  - Show-ahead: D_pop = mem[rd_ptr] registered; write at edge N into empty FIFO ->
//    pndng=1, D_pop=wr_data after edge N (visible cycle N+1). No combinational wr->pndng path.
//  - pop with pndng=1: rd_ptr++, count--; next entry on D_pop after same edge.
//  - pop with pndng=0: ignored, no state change, no error.
//  - wr_en with full=0: mem[wr_ptr]=wr_data, wr_ptr++, count++.
//  - wr_en with full=1 and pop=0: write dropped, overflow=1 for one cycle, data unchanged.
//  - wr_en & pop while full: both accepted, count stays depth, no overflow.
//  - wr_en & pop while empty: pop ignored, write accepted, count=1.
//  - wr_en & pop otherwise: count unchanged, both pointers advance.
//  - Pointers log2(depth) bits, wrap depth-1 -> 0 naturally; full/empty from count only.
//  - Order strictly FIFO; D_pop stable while pndng=1 and pop=0.
//  - full/almost_full/pndng registered, all consistent with count in the same cycle.
// CONFIGURATION
//  BUS_FIFO_STATS_EN defined: ovf_cnt increments on each overflow pulse, saturates at 16'hFFFF;
//   hwm = max(count) since reset; both reset to 0.
//  Not defined: ovf_cnt/hwm ports and logic absent; all other behaviour identical.
// STRUCTURE
//  Package bus_drv_pkg: typedef logic [pckg_sz-1:0] pckg_t, broadcast/ID field constants
//   (ID = pckg[pckg_sz-1 -: 8], BCAST_ID = 8'hFF), shared with arbiter, agent and checker.
//  Sub-module bus_fifo_mem: simple dual-port storage array (1 write, 1 async read port);
//   bus_drv_fifo holds pointers, count, flags and the D_pop register.
// TESTING
//  1 Reset, write 16'hA501 -> next cycle pndng=1, D_pop=16'hA501, count=1; pop -> pndng=0.
//  2 Write 8 words 0x0100..0x0107 -> full=1, almost_full from 6th write; 9th write 0xDEAD
//    -> overflow pulse, count=8, pops return 0x0100..0x0107 in order.
//  3 Full FIFO, wr_en+pop same cycle with 0xBEEF -> no overflow, count=8, 0xBEEF popped last.
//  4 Empty FIFO, wr_en+pop same cycle -> pop ignored, count=1, D_pop=written word.
//  5 Fill 5 entries, assert reset_n=0 mid-cycle -> pndng/count/full drop immediately; 24
//    write/pop cycles afterwards verify pointer wrap past depth with correct order.
//  6 BUS_FIFO_STATS_EN: 3 dropped writes -> ovf_cnt=3, hwm=8; without macro, elaboration
//    clean with ovf_cnt/hwm absent.

Source files
------------

// File: rtl/bus_drv_pkg.sv
// ============================================================================
// Module  : bus_drv_pkg
// Brief   : Packet type and ID-field constants shared by the bus driver FIFO,
//           arbiter, agent and checker.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_drv_pkg;

    localparam int PCKG_SZ = 16;

    typedef logic [PCKG_SZ-1:0] pckg_t;

    // Destination ID occupies the top byte of every packet.
    localparam int          ID_W     = 8;
    localparam int          ID_MSB   = PCKG_SZ - 1;
    localparam logic [7:0]  BCAST_ID = 8'hFF;

    function automatic logic [ID_W-1:0] get_id(input pckg_t pkt);
        return pkt[ID_MSB -: ID_W];
    endfunction

    function automatic logic is_bcast(input pckg_t pkt);
        return get_id(pkt) == BCAST_ID;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bus_fifo_mem.sv
// ============================================================================
// Module  : bus_fifo_mem
// Brief   : Simple dual-port storage array, one synchronous write port and one
//           asynchronous read port. Contents are never reset.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_fifo_mem #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/bus_drv_fifo.sv
// ============================================================================
// Module  : bus_drv_fifo
// Brief   : Per-device show-ahead transmit FIFO feeding one arbiter port.
//           Define BUS_FIFO_STATS_EN to add the ovf_cnt / hwm statistics ports.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_drv_fifo
    import bus_drv_pkg::*;
#(
    parameter  int pckg_sz = PCKG_SZ,
    parameter  int depth   = 8,
    parameter  int af_lvl  = 6,
    localparam int AW      = $clog2(depth),
    localparam int CW      = $clog2(depth + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               wr_en,
    input  logic [pckg_sz-1:0] wr_data,
    output logic               full,
    output logic               almost_full,
    output logic               overflow,
    input  logic               pop,
    output logic               pndng,
    output logic [pckg_sz-1:0] D_pop,
    output logic [CW-1:0]      count
`ifdef BUS_FIFO_STATS_EN
    ,
    output logic [15:0]        ovf_cnt,
    output logic [CW-1:0]      hwm
`endif
);

    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               full_q, full_d;
    logic               af_q, af_d;
    logic               pndng_q, pndng_d;
    logic               ovf_q, ovf_d;
    logic [pckg_sz-1:0] dpop_q, dpop_d;

    logic               w_pop_ok;
    logic               w_wr_ok;
    logic [CW-1:0]      w_remain;
    logic [pckg_sz-1:0] w_rdata;

    bus_fifo_mem #(
        .WIDTH (pckg_sz),
        .DEPTH (depth)
    ) u_mem (
        .clk     (clk),
        .we_i    (w_wr_ok),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data),
        .raddr_i (rd_ptr_d),
        .rdata_o (w_rdata)
    );

    always_comb begin
        w_pop_ok = pop & pndng_q;
        w_wr_ok  = wr_en & (~full_q | w_pop_ok);
        ovf_d    = wr_en & full_q & ~pop;
        rd_ptr_d = rd_ptr_q + AW'(w_pop_ok);
        wr_ptr_d = wr_ptr_q + AW'(w_wr_ok);
        w_remain = count_q - CW'(w_pop_ok);
        count_d  = w_remain + CW'(w_wr_ok);
        full_d   = (count_d == CW'(depth));
        af_d     = (count_d >= CW'(af_lvl));
        pndng_d  = (count_d != '0);
        // The new head is the word being written only when nothing else is left.
        if (w_wr_ok && (w_remain == '0)) begin
            dpop_d = wr_data;
        end else if (count_d != '0) begin
            dpop_d = w_rdata;
        end else begin
            dpop_d = dpop_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            af_q     <= 1'b0;
            pndng_q  <= 1'b0;
            ovf_q    <= 1'b0;
            dpop_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            af_q     <= af_d;
            pndng_q  <= pndng_d;
            ovf_q    <= ovf_d;
            dpop_q   <= dpop_d;
        end
    end

    assign full        = full_q;
    assign almost_full = af_q;
    assign overflow    = ovf_q;
    assign pndng       = pndng_q;
    assign D_pop       = dpop_q;
    assign count       = count_q;

`ifdef BUS_FIFO_STATS_EN
    logic [15:0]   ovf_cnt_q;
    logic [CW-1:0] hwm_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_cnt_q <= '0;
            hwm_q     <= '0;
        end else begin
            if (ovf_d && (ovf_cnt_q != 16'hFFFF)) begin
                ovf_cnt_q <= ovf_cnt_q + 16'd1;
            end
            if (count_d > hwm_q) begin
                hwm_q <= count_d;
            end
        end
    end

    assign ovf_cnt = ovf_cnt_q;
    assign hwm     = hwm_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bus_drv_fifo.sv
// ============================================================================
// Module  : tb_bus_drv_fifo
// Brief   : Scoreboard bench for bus_drv_fifo (optionally with BUS_FIFO_STATS_EN).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_drv_fifo;

    localparam int DEPTH = 8;
    localparam int AF    = 6;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [15:0] wr_data = '0;
    logic        pop = 1'b0;
    logic        full, almost_full, overflow, pndng;
    logic [15:0] D_pop;
    logic [3:0]  count;
`ifdef BUS_FIFO_STATS_EN
    logic [15:0] ovf_cnt;
    logic [3:0]  hwm;
`endif

    bus_drv_fifo #(.pckg_sz(16), .depth(DEPTH), .af_lvl(AF)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .full        (full),
        .almost_full (almost_full),
        .overflow    (overflow),
        .pop         (pop),
        .pndng       (pndng),
        .D_pop       (D_pop),
        .count       (count)
`ifdef BUS_FIFO_STATS_EN
        ,
        .ovf_cnt     (ovf_cnt),
        .hwm         (hwm)
`endif
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] sbq[$];
    int          mcnt = 0;
    int          movf = 0;
    int          mhwm = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Head of the FIFO must match the scoreboard whenever data is pending.
    always @(negedge clk) begin
        if (reset_n && pndng) begin
            n_cmp++;
            if (sbq.size() == 0) begin
                n_bad++;
                $display("FAIL head: pndng=1 with no expected entry, D_pop=0x%0h", D_pop);
            end else begin
                if (D_pop !== sbq[0]) begin
                    n_bad++;
                    $display("FAIL head: D_pop=0x%0h, expected 0x%0h at %0t", D_pop, sbq[0], $time);
                end
                if (pop) void'(sbq.pop_front());
            end
        end
    end

    task automatic cycle(input logic w, input logic [15:0] d, input logic p);
        logic p_ok, w_ok, e_ovf;
        wr_en   = w;
        wr_data = d;
        pop     = p;
        p_ok  = p && (mcnt > 0);
        w_ok  = w && ((mcnt < DEPTH) || p_ok);
        e_ovf = w && (mcnt == DEPTH) && !p;
        if (w_ok) sbq.push_back(d);
        mcnt = mcnt + int'(w_ok) - int'(p_ok);
        if (e_ovf && movf != 16'hFFFF) movf++;
        if (mcnt > mhwm) mhwm = mcnt;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        pop   = 1'b0;
        chk("count", int'(count), mcnt);
        chk("full", int'(full), int'(mcnt == DEPTH));
        chk("almost_full", int'(almost_full), int'(mcnt >= AF));
        chk("pndng", int'(pndng), int'(mcnt != 0));
        chk("overflow", int'(overflow), int'(e_ovf));
    endtask

    task automatic model_reset();
        mcnt = 0;
        movf = 0;
        mhwm = 0;
        sbq.delete();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        chk("rst_count", int'(count), 0);
        chk("rst_pndng", int'(pndng), 0);
        chk("rst_full", int'(full), 0);
        chk("rst_af", int'(almost_full), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_dpop", int'(D_pop), 0);

        // 1: single word, visible the cycle after the write
        cycle(1'b1, 16'hA501, 1'b0);
        chk("t1_dpop", int'(D_pop), 16'hA501);
        cycle(1'b0, 16'h0, 1'b1);

        // 2: fill, overflow, drain in order
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 16'h0100 + 16'(i), 1'b0);
        cycle(1'b1, 16'hDEAD, 1'b0);
        cycle(1'b0, 16'h0, 1'b0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 16'h0, 1'b1);

        // 3: simultaneous write and pop while full
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 16'h0200 + 16'(i), 1'b0);
        cycle(1'b1, 16'hBEEF, 1'b1);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 16'h0, 1'b1);
        cycle(1'b0, 16'h0, 1'b1);

        // 4: simultaneous write and pop while empty
        cycle(1'b1, 16'h4444, 1'b1);
        chk("t4_dpop", int'(D_pop), 16'h4444);
        cycle(1'b0, 16'h0, 1'b1);

        // 5: mid-cycle reset discards contents, then wrap the pointers
        for (int i = 0; i < 5; i++) cycle(1'b1, 16'h0300 + 16'(i), 1'b0);
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        chk("mrst_count", int'(count), 0);
        chk("mrst_pndng", int'(pndng), 0);
        chk("mrst_full", int'(full), 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 24; i++) cycle(1'b1, 16'h0500 + 16'(i), (i >= 3) && (i % 5 != 4));
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 16'h0, 1'b1);

        // 6: three dropped writes after a fresh reset
        #2 reset_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 16'h0600 + 16'(i), 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'hBAD0 + 16'(i), 1'b0);
`ifdef BUS_FIFO_STATS_EN
        chk("ovf_cnt", int'(ovf_cnt), movf);
        chk("hwm", int'(hwm), mhwm);
`endif
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 16'h0, 1'b1);
        chk("sb_empty", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
